// File: rtl/vga_pixel_feeder_if.sv
// Signal bundle between the pixel pipeline, the pixel feeder and the VGA timing
// generator. The master modport is the environment side; the slave modport is the feeder.
interface vga_pixel_feeder_if #(
    parameter int AW = 10
);
    // Upstream push handshake: a pixel transfers on a rising clk edge where in_valid
    // and in_ready are both high; in_valid may be raised regardless of in_ready, and
    // in_sof/in_r/in_g/in_b are only meaningful while in_valid is high.
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [7:0]    in_r;
    logic [7:0]    in_g;
    logic [7:0]    in_b;

    logic          en;
    logic          data_ack;
    logic          frame_start;
    logic [7:0]    out_r;
    logic [7:0]    out_g;
    logic [7:0]    out_b;

    logic [AW:0]   level;
    logic          underflow;
    logic          resync;
    logic [15:0]   underflow_cnt;
    logic [15:0]   resync_cnt;

    modport master (
        output in_valid, in_sof, in_r, in_g, in_b,
        output en, data_ack, frame_start,
        input  in_ready, out_r, out_g, out_b,
        input  level, underflow, resync, underflow_cnt, resync_cnt
    );

    modport slave (
        input  in_valid, in_sof, in_r, in_g, in_b,
        input  en, data_ack, frame_start,
        output in_ready, out_r, out_g, out_b,
        output level, underflow, resync, underflow_cnt, resync_cnt
    );
endinterface

// File: rtl/vga_pixel_feeder.sv
// Show-ahead pixel FIFO that aligns buffered frames to the VGA generator's frame_start.
// Define VGA_FEEDER_STATS_EN to build the saturating underflow/resync event counters.
module vga_pixel_feeder #(
    parameter int AW = 10
) (
    input  logic               clk,
    input  logic               reset,
    vga_pixel_feeder_if.slave  bus,
    output logic [1:0]         dbg_state_o
);

    typedef struct packed {
        logic       sof;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

    pix_t          mem_q [DEPTH];
    pix_t          head_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   mem_cnt_q, mem_cnt_d;
    logic          head_vld_q, head_vld_d;
    state_t        state_q, state_d;
    logic          first_q, first_d;
    logic          underflow_q, underflow_d;
    logic          resync_q, resync_d;

    logic          full;
    logic          push;
    logic          pop;
    logic          load;
    logic          rd;
    pix_t          wr_pix;

    assign full   = (mem_cnt_q == DEPTH_CNT);
    assign push   = bus.in_valid && !full;
    assign rd     = bus.en && bus.data_ack;
    assign wr_pix = {bus.in_sof, bus.in_r, bus.in_g, bus.in_b};

    // Read-side FSM: decides when the head register is consumed.
    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        pop         = 1'b0;
        underflow_d = 1'b0;
        resync_d    = 1'b0;
        case (state_q)
            ST_SEEK: begin
                if (head_vld_q) begin
                    if (head_q.sof) begin
                        state_d = ST_WAIT;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.en && bus.frame_start) begin
                    state_d = ST_STREAM;
                    first_d = 1'b1;
                end
            end
            ST_STREAM: begin
                if (rd) begin
                    if (!head_vld_q) begin
                        underflow_d = 1'b1;
                        state_d     = ST_SEEK;
                    end else if (head_q.sof && !first_q) begin
                        // Upstream frame ended early: hold the new sof until the next frame_start.
                        resync_d = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        pop     = 1'b1;
                        first_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_SEEK;
            end
        endcase
    end

    // Head register refills from memory whenever it is empty or being consumed.
    always_comb begin
        load       = (!head_vld_q || pop) && (mem_cnt_q != '0);
        head_vld_d = load || (head_vld_q && !pop);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
        mem_cnt_d  = mem_cnt_q;
        case ({push, load})
            2'b10:   mem_cnt_d = mem_cnt_q + (AW+1)'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - (AW+1)'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_pix;
        end
        if (load) begin
            head_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            head_vld_q  <= 1'b0;
            state_q     <= ST_SEEK;
            first_q     <= 1'b0;
            underflow_q <= 1'b0;
            resync_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            head_vld_q  <= head_vld_d;
            state_q     <= state_d;
            first_q     <= first_d;
            underflow_q <= underflow_d;
            resync_q    <= resync_d;
        end
    end

`ifdef VGA_FEEDER_STATS_EN
    logic [15:0] underflow_cnt_q;
    logic [15:0] resync_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_cnt_q <= '0;
            resync_cnt_q    <= '0;
        end else begin
            if (underflow_d && (underflow_cnt_q != 16'hFFFF)) begin
                underflow_cnt_q <= underflow_cnt_q + 16'd1;
            end
            if (resync_d && (resync_cnt_q != 16'hFFFF)) begin
                resync_cnt_q <= resync_cnt_q + 16'd1;
            end
        end
    end

    assign bus.underflow_cnt = underflow_cnt_q;
    assign bus.resync_cnt    = resync_cnt_q;
`else
    assign bus.underflow_cnt = 16'h0;
    assign bus.resync_cnt    = 16'h0;
`endif

    // Blanking is a pure mux on the head register so the generator sees no extra latency.
    assign {bus.out_r, bus.out_g, bus.out_b} =
        ((state_q == ST_STREAM) && head_vld_q) ? {head_q.r, head_q.g, head_q.b} : 24'h0;

    assign bus.in_ready  = !full;
    assign bus.level     = mem_cnt_q + {{AW{1'b0}}, head_vld_q};
    assign bus.underflow = underflow_q;
    assign bus.resync    = resync_q;
    assign dbg_state_o   = state_q;

    assert property (@(posedge clk) disable iff (reset) !(underflow_q && resync_q));
    assert property (@(posedge clk) disable iff (reset) mem_cnt_q <= DEPTH_CNT);

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Self-checking bench for vga_pixel_feeder: directed scenarios plus randomized streaming
// against a queue-based model of the buffered pixels.
module tb_vga_pixel_feeder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  // dbg_state_o encoding
  localparam logic [1:0] S_SEEK   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic        clk;
  logic        reset;
  logic [1:0]  dbg_state;
  logic [23:0] out_rgb;

  int total;
  int bad;
  int exp_uf;
  int exp_rs;
  int uf_seen;
  int rs_seen;
  logic [23:0] exp_q[$];

  vga_pixel_feeder_if #(.AW(AW)) bus ();

  vga_pixel_feeder #(.AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  assign out_rgb = {bus.out_r, bus.out_g, bus.out_b};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.underflow) uf_seen++;
      if (bus.resync) rs_seen++;
    end
  end

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef VGA_FEEDER_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'h0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_sof      = 1'b0;
    bus.in_r        = 8'h0;
    bus.in_g        = 8'h0;
    bus.in_b        = 8'h0;
    bus.en          = 1'b0;
    bus.data_ack    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic push_one(input logic sof, input logic [23:0] px);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    {bus.in_r, bus.in_g, bus.in_b} = px;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic pulse_frame_start();
    bus.en          = 1'b1;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    total++; if (out_rgb !== 24'h0) begin bad++; $display("FAIL reset_out: got %06h want 000000", out_rgb); end
    total++; if (bus.level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    total++; if ({bus.underflow, bus.resync} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %02b want 00", {bus.underflow, bus.resync}); end
    total++; if ({bus.underflow_cnt, bus.resync_cnt} !== 32'h0) begin bad++; $display("FAIL reset_cnts: got %08h want 00000000", {bus.underflow_cnt, bus.resync_cnt}); end
    total++; if (dbg_state !== S_SEEK) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_SEEK); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.level !== '0 || dbg_state !== S_SEEK) begin bad++; $display("FAIL reset_idle: got level=%0d state=%0d want 0/%0d", bus.level, dbg_state, S_SEEK); end
  endtask

  task automatic test_basic_frame();
    logic [23:0] px;
    int uf0, rs0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      px = 24'($urandom);
      exp_q.push_back(px);
      push_one(i == 0, px);
    end
    repeat (3) @(negedge clk);
    total++; if (dbg_state !== S_WAIT) begin bad++; $display("FAIL basic_wait: got %0d want %0d", dbg_state, S_WAIT); end
    total++; if (bus.level !== 11'd8) begin bad++; $display("FAIL basic_level: got %0d want 8", bus.level); end
    total++; if (out_rgb !== 24'h0) begin bad++; $display("FAIL basic_blank: got %06h want 000000", out_rgb); end
    uf0 = uf_seen;
    rs0 = rs_seen;
    pulse_frame_start();
    total++; if (dbg_state !== S_STREAM) begin bad++; $display("FAIL basic_stream: got %0d want %0d", dbg_state, S_STREAM); end
    for (int i = 0; i < 8; i++) begin
      total++; if (out_rgb !== exp_q[0]) begin bad++; $display("FAIL basic_pix%0d: got %06h want %06h", i, out_rgb, exp_q[0]); end
      bus.data_ack = 1'b1;
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    bus.data_ack = 1'b0;
    total++; if (bus.level !== '0) begin bad++; $display("FAIL basic_drain: got %0d want 0", bus.level); end
    total++; if (out_rgb !== 24'h0) begin bad++; $display("FAIL basic_empty_out: got %06h want 000000", out_rgb); end
    @(negedge clk);
    total++; if (uf_seen != uf0 || rs_seen != rs0) begin bad++; $display("FAIL basic_pulses: got uf=%0d rs=%0d want 0/0", uf_seen - uf0, rs_seen - rs0); end
  endtask

  task automatic test_latency();
    logic [23:0] px;
    px = 24'($urandom);
    push_one(1'b0, px);
    total++; if (out_rgb !== 24'h0) begin bad++; $display("FAIL lat_t1_out: got %06h want 000000", out_rgb); end
    total++; if (bus.level !== 11'd1) begin bad++; $display("FAIL lat_t1_level: got %0d want 1", bus.level); end
    @(negedge clk);
    total++; if (out_rgb !== px) begin bad++; $display("FAIL lat_t2_out: got %06h want %06h", out_rgb, px); end
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    total++; if (bus.level !== '0 || out_rgb !== 24'h0) begin bad++; $display("FAIL lat_pop: got level=%0d out=%06h want 0/000000", bus.level, out_rgb); end
  endtask

  task automatic test_underflow();
    bus.en       = 1'b1;
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    exp_uf++;
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL uf_pulse: got %0b want 1", bus.underflow); end
    total++; if (out_rgb !== 24'h0) begin bad++; $display("FAIL uf_out: got %06h want 000000", out_rgb); end
    total++; if (dbg_state !== S_SEEK) begin bad++; $display("FAIL uf_state: got %0d want %0d", dbg_state, S_SEEK); end
    total++; if (bus.underflow_cnt !== cnt_exp(exp_uf)) begin bad++; $display("FAIL uf_cnt: got %0d want %0d", bus.underflow_cnt, cnt_exp(exp_uf)); end
    @(negedge clk);
    total++; if ({bus.underflow, bus.resync} !== 2'b00) begin bad++; $display("FAIL uf_one_cycle: got %02b want 00", {bus.underflow, bus.resync}); end
  endtask

  task automatic test_seek_discard();
    logic [23:0] px;
    int n, guard, uf0, rs0;
    n = $urandom_range(4, 12);
    exp_q.delete();
    bus.en = 1'b0;
    for (int i = 0; i < 3 + n; i++) begin
      while ($urandom_range(0, 2) == 0) @(negedge clk);
      px = 24'($urandom);
      if (i >= 3) exp_q.push_back(px);
      push_one(i == 3, px);
    end
    repeat (6) @(negedge clk);
    total++; if (dbg_state !== S_WAIT) begin bad++; $display("FAIL seek_wait: got %0d want %0d", dbg_state, S_WAIT); end
    total++; if (bus.level !== (AW+1)'(n)) begin bad++; $display("FAIL seek_level: got %0d want %0d", bus.level, n); end
    bus.en       = 1'b1;
    bus.data_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.data_ack = 1'b0;
    total++; if (bus.level !== (AW+1)'(n) || dbg_state !== S_WAIT) begin bad++; $display("FAIL wait_ignores_ack: got level=%0d state=%0d want %0d/%0d", bus.level, dbg_state, n, S_WAIT); end
    uf0 = uf_seen;
    rs0 = rs_seen;
    pulse_frame_start();
    guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      total++; if (out_rgb !== exp_q[0]) begin bad++; $display("FAIL seek_stream_pix: got %06h want %06h", out_rgb, exp_q[0]); end
      bus.en       = 1'($urandom_range(0, 1));
      bus.data_ack = 1'($urandom_range(0, 1));
      if (bus.en && bus.data_ack) void'(exp_q.pop_front());
      @(negedge clk);
      guard++;
    end
    bus.data_ack = 1'b0;
    bus.en       = 1'b1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL seek_stream_timeout: got %0d left want 0", exp_q.size()); end
    @(negedge clk);
    total++; if (bus.level !== '0 || uf_seen != uf0 || rs_seen != rs0) begin bad++; $display("FAIL seek_stream_end: got level=%0d uf=%0d rs=%0d want 0/0/0", bus.level, uf_seen - uf0, rs_seen - rs0); end
  endtask

  task automatic test_resync();
    logic [23:0] qa[$];
    logic [23:0] qb[$];
    logic [23:0] px;
    // drive into SEEK via an underflow
    bus.en       = 1'b1;
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    exp_uf++;
    total++; if (bus.underflow !== 1'b1 || dbg_state !== S_SEEK) begin bad++; $display("FAIL rs_pre_uf: got uf=%0b state=%0d want 1/%0d", bus.underflow, dbg_state, S_SEEK); end
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      px = 24'($urandom);
      if (i < 5) qa.push_back(px); else qb.push_back(px);
      push_one(i == 0 || i == 5, px);
    end
    repeat (4) @(negedge clk);
    total++; if (dbg_state !== S_WAIT || bus.level !== 11'd10) begin bad++; $display("FAIL rs_wait: got state=%0d level=%0d want %0d/10", dbg_state, bus.level, S_WAIT); end
    pulse_frame_start();
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin
        total++; if (out_rgb !== qa[i]) begin bad++; $display("FAIL rs_frame_a%0d: got %06h want %06h", i, out_rgb, qa[i]); end
      end
      if (i == 6) begin
        total++; if (bus.resync !== 1'b1 || dbg_state !== S_WAIT) begin bad++; $display("FAIL rs_pulse: got rs=%0b state=%0d want 1/%0d", bus.resync, dbg_state, S_WAIT); end
      end
      if (i == 7) begin
        total++; if (bus.resync !== 1'b0) begin bad++; $display("FAIL rs_one_cycle: got %0b want 0", bus.resync); end
      end
      bus.data_ack = 1'b1;
      @(negedge clk);
    end
    bus.data_ack = 1'b0;
    exp_rs++;
    total++; if (bus.level !== 11'd5 || dbg_state !== S_WAIT) begin bad++; $display("FAIL rs_hold: got level=%0d state=%0d want 5/%0d", bus.level, dbg_state, S_WAIT); end
    total++; if (bus.resync_cnt !== cnt_exp(exp_rs) || bus.underflow_cnt !== cnt_exp(exp_uf)) begin bad++; $display("FAIL rs_cnts: got %0d/%0d want %0d/%0d", bus.resync_cnt, bus.underflow_cnt, cnt_exp(exp_rs), cnt_exp(exp_uf)); end
    pulse_frame_start();
    for (int i = 0; i < 5; i++) begin
      total++; if (out_rgb !== qb[i]) begin bad++; $display("FAIL rs_frame_b%0d: got %06h want %06h", i, out_rgb, qb[i]); end
      bus.data_ack = 1'b1;
      @(negedge clk);
    end
    bus.data_ack = 1'b0;
    total++; if (bus.level !== '0) begin bad++; $display("FAIL rs_drain: got %0d want 0", bus.level); end
  endtask

  task automatic test_full();
    logic [23:0] px;
    int pushed, guard, rs0, uf0;
    logic do_push, do_pop;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    exp_uf = 0;
    exp_rs = 0;
    exp_q.delete();
    pushed = 0;
    guard  = 0;
    while (pushed < DEPTH + 1 && guard < 3 * DEPTH) begin
      if (bus.in_ready) begin
        px = 24'($urandom);
        exp_q.push_back(px);
        push_one(pushed == 0, px);
        pushed++;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    @(negedge clk);
    total++; if (pushed != DEPTH + 1) begin bad++; $display("FAIL full_fill_timeout: got %0d want %0d", pushed, DEPTH + 1); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %0b want 0", bus.in_ready); end
    total++; if (bus.level !== (AW+1)'(DEPTH + 1)) begin bad++; $display("FAIL full_level: got %0d want %0d", bus.level, DEPTH + 1); end
    push_one(1'b0, 24'hABCDEF);
    total++; if (bus.level !== (AW+1)'(DEPTH + 1)) begin bad++; $display("FAIL full_blocked: got %0d want %0d", bus.level, DEPTH + 1); end
    uf0 = uf_seen;
    rs0 = rs_seen;
    pulse_frame_start();
    total++; if (out_rgb !== exp_q[0]) begin bad++; $display("FAIL full_first: got %06h want %06h", out_rgb, exp_q[0]); end
    bus.data_ack = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    bus.data_ack = 1'b0;
    total++; if (bus.level !== (AW+1)'(DEPTH) || bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_after_pop: got level=%0d rdy=%0b want %0d/1", bus.level, bus.in_ready, DEPTH); end
    px = 24'($urandom);
    bus.data_ack = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(px);
    push_one(1'b0, px);
    bus.data_ack = 1'b0;
    total++; if (bus.level !== (AW+1)'(DEPTH)) begin bad++; $display("FAIL full_push_pop: got %0d want %0d", bus.level, DEPTH); end
    total++; if (out_rgb !== exp_q[0]) begin bad++; $display("FAIL full_push_pop_pix: got %06h want %06h", out_rgb, exp_q[0]); end
    for (int c = 0; c < 200; c++) begin
      total++; if (out_rgb !== exp_q[0]) begin bad++; $display("FAIL full_rand_pix: got %06h want %06h", out_rgb, exp_q[0]); end
      total++; if (bus.level !== (AW+1)'(exp_q.size())) begin bad++; $display("FAIL full_rand_level: got %0d want %0d", bus.level, exp_q.size()); end
      total++; if (bus.in_ready !== (exp_q.size() <= DEPTH)) begin bad++; $display("FAIL full_rand_ready: got %0b want %0b", bus.in_ready, exp_q.size() <= DEPTH); end
      do_push = 1'($urandom_range(0, 1)) && bus.in_ready;
      do_pop  = 1'($urandom_range(0, 1));
      px = 24'($urandom);
      bus.in_valid = do_push;
      bus.in_sof   = 1'b0;
      {bus.in_r, bus.in_g, bus.in_b} = px;
      bus.data_ack = do_pop;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(px);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.data_ack = 1'b0;
    @(negedge clk);
    total++; if (uf_seen != uf0 || rs_seen != rs0) begin bad++; $display("FAIL full_pulses: got uf=%0d rs=%0d want 0/0", uf_seen - uf0, rs_seen - rs0); end
  endtask

  task automatic test_reset_mid_stream();
    total++; if (dbg_state !== S_STREAM || bus.level < 11'd100) begin bad++; $display("FAIL mid_pre: got state=%0d level=%0d want %0d/>=100", dbg_state, bus.level, S_STREAM); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.level !== '0) begin bad++; $display("FAIL mid_level: got %0d want 0", bus.level); end
    total++; if (out_rgb !== 24'h0) begin bad++; $display("FAIL mid_out: got %06h want 000000", out_rgb); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %0b want 1", bus.in_ready); end
    total++; if (dbg_state !== S_SEEK) begin bad++; $display("FAIL mid_state: got %0d want %0d", dbg_state, S_SEEK); end
    total++; if ({bus.underflow_cnt, bus.resync_cnt} !== 32'h0) begin bad++; $display("FAIL mid_cnts: got %08h want 00000000", {bus.underflow_cnt, bus.resync_cnt}); end
    reset = 1'b0;
    exp_q.delete();
    push_one(1'b0, 24'($urandom));
    repeat (4) @(negedge clk);
    total++; if (bus.level !== '0 || dbg_state !== S_SEEK) begin bad++; $display("FAIL mid_recover_discard: got level=%0d state=%0d want 0/%0d", bus.level, dbg_state, S_SEEK); end
    push_one(1'b1, 24'($urandom));
    repeat (4) @(negedge clk);
    total++; if (bus.level !== 11'd1 || dbg_state !== S_WAIT) begin bad++; $display("FAIL mid_recover_sof: got level=%0d state=%0d want 1/%0d", bus.level, dbg_state, S_WAIT); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total   = 0;
    bad     = 0;
    exp_uf  = 0;
    exp_rs  = 0;
    uf_seen = 0;
    rs_seen = 0;
    reset   = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_latency();
    test_underflow();
    test_seek_discard();
    test_resync();
    test_full();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_feeder.md
# vga_pixel_feeder

Pixel source stage directly upstream of the VGA timing generator. It buffers the processed RGB pixel stream in a synchronous FIFO and aligns each buffered frame to the generator's frame-start strobe. It presents show-ahead RGB and advances one pixel per `data_ack` pulse, so the generator always samples the pixel for the current position. Underflow and frame misalignment are detected and recovered from automatically.

## Interface
- `AW`, 10: FIFO address width; depth = 2^AW entries.
- `clk`  in  1  pixel clock; both FIFO sides are synchronous to it.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  upstream pixel valid.
- `in_ready`  out  1  `!full`; a push occurs when `in_valid && in_ready`.
- `in_sof`  in  1  marks the first pixel (x=0, y=0) of a frame.
- `in_r`, `in_g`, `in_b`  in  8 each  upstream pixel.
- `en`  in  1  clock enable of the VGA timing generator; qualifies all read-side events.
- `data_ack`  in  1  pixel consumed / advance request from the timing generator.
- `frame_start`  in  1  one-cycle strobe from the generator at x=1, y=0.
- `out_r`, `out_g`, `out_b`  out  8 each  show-ahead pixel to the generator.
- `level`  out  AW+1  entries held, head register included.
- `underflow`  out  1  one-cycle pulse on a pop request while empty in STREAM.
- `resync`  out  1  one-cycle pulse when STREAM is abandoned for an early `sof`.
- `underflow_cnt`, `resync_cnt`  out  16 each  saturating event counters (see Configuration).

## Operation
- Each FIFO entry is 25 bits: {sof, r, g, b}.
- Memory uses registered writes and a first-word-fall-through head register (`head_vld`, `head`).
- Read-side pop request: `rd = en && data_ack`.
- The read-side FSM has three states.
- SEEK (reset state): pops the head while `head_vld && !head.sof`, independent of `en`, discarding partial frames. Goes to WAIT when `head_vld && head.sof`.
- WAIT: holds the head; `data_ack` is ignored. Goes to STREAM when `en && frame_start`, and sets flag `first`.
- STREAM: on `rd`:
  - If `!head_vld`: pulse `underflow`, go to SEEK.
  - Else if `head.sof && !first`: no pop, pulse `resync`, go to WAIT. This is the upstream short-frame case.
  - Otherwise: pop and clear `first`.
- Blanking: `out_* = (state==STREAM && head_vld) ? head.rgb : 0`. This is a combinational mux from the head register, with no added latency.
- Write side ignores `en`. A push while full cannot occur. Simultaneous push and pop is legal at any level, and `level` is unchanged by it.
- `level` is the count of valid entries plus `head_vld`, range 0..2^AW+1. `full` is asserted when the memory holds 2^AW entries.
- Reset values:
  - `in_ready` = 1; `out_*` = 0; `level` = 0; `underflow` = 0; `resync` = 0; counters = 0.
  - State = SEEK; `head_vld` = 0; `first` = 0.
- Reset mid-frame discards all contents. Recovery passes through SEEK for the next `sof`.

## Timing
- Push at cycle t into an empty FIFO: `head_vld` is set at t+2, and `out_*` is valid at t+2 if in STREAM.
- Pop at cycle t: the next entry appears on `out_*` at t+1 if one was available at least 2 cycles earlier. Otherwise `head_vld` drops at t+1.
- The `frame_start` to STREAM transition takes 1 cycle. The first `data_ack` after that pops the sof pixel.
- `underflow` and `resync` pulse in the cycle after the triggering `rd`, together with the state change.
- Sustained throughput is one pop per cycle and one push per cycle.

## Configuration
- `VGA_FEEDER_STATS_EN` defined:
  - `underflow_cnt` and `resync_cnt` increment once per respective pulse and saturate at 16'hFFFF.
  - Both are cleared by `reset` only.
- Not defined:
  - Both counters are constant 0, and no counter logic is synthesised.
  - Pulses, FSM and data path are identical in both builds.

## Test plan
- Push 8 pixels with `sof` on pixel 0, then pulse `frame_start` with `en`=1, then 8 `data_ack` -> `out_*` shows pixels 0..7 in order, `level` returns to 0, no pulses.
- Push 3 non-sof pixels, then a sof frame -> the 3 pixels are discarded in SEEK, `level` reflects only the sof frame, and WAIT is reached.
- In STREAM, issue `data_ack` with the FIFO drained -> `underflow`=1 for one cycle, `out_*`=0, state=SEEK, `underflow_cnt`=1 (0 without macro).
- Frame of 5 pixels followed by a sof frame while the generator acks 8 -> 6th ack finds head.sof: `resync` pulses, no pop, WAIT; the next `frame_start` outputs the new frame's pixel 0.
- Fill to 2^AW+1 entries -> `in_ready`=0; push and pop in the same cycle at level 2^AW -> level stays 2^AW.
- Assert `reset` mid-STREAM with 100 entries -> next cycle `level`=0, `out_*`=0, `in_ready`=1, state=SEEK.
